interlaken_latency_meter: RTL and testbench

Cycle-accurate latency meter on the `init_clk` domain, placed downstream of the Interlaken driver/repeater example-design pair and their test sequencer. It consumes two status levels: driver TX-busy as the start event and repeater RX-done as the stop event. It measures the `init_clk` cycles between their rising edges and keeps last/min/max/sample-count statistics per packet round trip, with a sticky timeout flag. An optional latency histogram is compiled in by macro.

---
 rtl/interlaken_lat_pkg.sv | 13 +
 rtl/interlaken_lat_edge_sync.sv | 32 +++
 rtl/interlaken_latency_meter.sv | 170 +++++++++++++++++
 tb/tb_interlaken_latency_meter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interlaken_lat_pkg.sv
// Shared types and constants for the Interlaken round-trip latency meter.
package interlaken_lat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_UPDATE  = 2'd2
   } lat_state_e;

   localparam int HIST_BINS = 8;
   localparam int HIST_W    = 16;

endpackage

// File: rtl/interlaken_lat_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detect.
// Raw edge to rise_o pulse is three clocks.
module interlaken_lat_edge_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic lvl_i,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;
   logic rise_q;

   // Synchronizer chain and one-cycle rise pulse
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= lvl_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/interlaken_latency_meter.sv
// Start/stop latency meter with last/min/max/count statistics and sticky timeout.
// Optional 8-bin latency histogram enabled by defining INTERLAKEN_LAT_HIST_EN.
module interlaken_latency_meter
   import interlaken_lat_pkg::*;
#(
   parameter int CNT_W       = 20,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int SAMPLES_W   = 16,
   parameter int BIN_SHIFT   = 4
) (
   input  logic                 init_clk,
   input  logic                 sys_reset_n,
   input  logic                 clear,
   input  logic                 start_lvl,
   input  logic                 stop_lvl,
   output logic                 busy,
   output logic                 meas_valid,
   output logic [CNT_W-1:0]     last_lat,
   output logic [CNT_W-1:0]     min_lat,
   output logic [CNT_W-1:0]     max_lat,
   output logic [SAMPLES_W-1:0] sample_cnt,
`ifdef INTERLAKEN_LAT_HIST_EN
   input  logic [2:0]           hist_sel,
   output logic [HIST_W-1:0]    hist_cnt,
`endif
   output logic                 timed_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   if ((64'(TIMEOUT_CYC) >= (64'(1) << CNT_W)) || (BIN_SHIFT >= CNT_W) || (CNT_W < 3)) begin : g_bad_cfg
      $error("interlaken_latency_meter: inconsistent CNT_W/TIMEOUT_CYC/BIN_SHIFT");
   end

   logic start_rise_s;
   logic stop_rise_s;

   lat_state_e           state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     last_lat_q;
   logic [CNT_W-1:0]     min_lat_q;
   logic [CNT_W-1:0]     max_lat_q;
   logic [SAMPLES_W-1:0] sample_cnt_q;
   logic                 busy_q;
   logic                 meas_valid_q;
   logic                 timed_out_q;

   interlaken_lat_edge_sync u_start_sync (
      .clk_i   (init_clk),
      .rst_n_i (sys_reset_n),
      .lvl_i   (start_lvl),
      .rise_o  (start_rise_s)
   );

   interlaken_lat_edge_sync u_stop_sync (
      .clk_i   (init_clk),
      .rst_n_i (sys_reset_n),
      .lvl_i   (stop_lvl),
      .rise_o  (stop_rise_s)
   );

   // Measurement FSM; stop beats timeout in MEASURE, start beats stop in IDLE
   always_ff @(posedge init_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_lat_q   <= '0;
         min_lat_q    <= '1;
         max_lat_q    <= '0;
         sample_cnt_q <= '0;
         busy_q       <= 1'b0;
         meas_valid_q <= 1'b0;
         timed_out_q  <= 1'b0;
      end else if (clear) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_lat_q   <= '0;
         min_lat_q    <= '1;
         max_lat_q    <= '0;
         sample_cnt_q <= '0;
         busy_q       <= 1'b0;
         meas_valid_q <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_rise_s) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_MEASURE;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (stop_rise_s) begin
                  last_lat_q   <= cnt_q + CNT_W'(1);
                  meas_valid_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_UPDATE;
               end else if (cnt_q == CNT_LAST) begin
                  timed_out_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  cnt_q        <= cnt_q + CNT_W'(1);
               end
            end
            ST_UPDATE: begin
               if (last_lat_q < min_lat_q) begin
                  min_lat_q <= last_lat_q;
               end
               if (last_lat_q > max_lat_q) begin
                  max_lat_q <= last_lat_q;
               end
               if (sample_cnt_q != {SAMPLES_W{1'b1}}) begin
                  sample_cnt_q <= sample_cnt_q + SAMPLES_W'(1);
               end
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign meas_valid = meas_valid_q;
   assign last_lat   = last_lat_q;
   assign min_lat    = min_lat_q;
   assign max_lat    = max_lat_q;
   assign sample_cnt = sample_cnt_q;
   assign timed_out  = timed_out_q;

`ifdef INTERLAKEN_LAT_HIST_EN
   logic [HIST_W-1:0] bins_q [HIST_BINS];
   logic [HIST_W-1:0] hist_cnt_q;
   logic [CNT_W-1:0]  lat_bin_s;
   logic [2:0]        bin_idx_s;

   assign lat_bin_s = last_lat_q >> BIN_SHIFT;
   assign bin_idx_s = (lat_bin_s > CNT_W'(7)) ? 3'd7 : lat_bin_s[2:0];

   // Saturating bin counters, bumped in UPDATE alongside min/max
   always_ff @(posedge init_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         for (int i = 0; i < HIST_BINS; i++) begin
            bins_q[i] <= '0;
         end
         hist_cnt_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < HIST_BINS; i++) begin
            bins_q[i] <= '0;
         end
         hist_cnt_q <= '0;
      end else begin
         if ((state_q == ST_UPDATE) && (bins_q[bin_idx_s] != {HIST_W{1'b1}})) begin
            bins_q[bin_idx_s] <= bins_q[bin_idx_s] + HIST_W'(1);
         end
         hist_cnt_q <= bins_q[hist_sel];
      end
   end

   assign hist_cnt = hist_cnt_q;
`endif

endmodule

// File: tb/tb_interlaken_latency_meter.sv
// Self-checking bench: table of directed measurements, hand-written corner cases,
// then random latencies against a behavioural statistics model.
module tb_interlaken_latency_meter;

   localparam int CNT_W     = 20;
   localparam int TO        = 600;
   localparam int SAMPLES_W = 16;
   localparam int BIN_SHIFT = 4;
   localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

   logic init_clk = 1'b0;
   logic sys_reset_n = 1'b0;
   logic clear = 1'b0;
   logic start_lvl = 1'b0;
   logic stop_lvl = 1'b0;
   logic busy;
   logic meas_valid;
   logic [CNT_W-1:0] last_lat;
   logic [CNT_W-1:0] min_lat;
   logic [CNT_W-1:0] max_lat;
   logic [SAMPLES_W-1:0] sample_cnt;
   logic timed_out;
`ifdef INTERLAKEN_LAT_HIST_EN
   logic [2:0]  hist_sel = 3'd0;
   logic [15:0] hist_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 init_clk = ~init_clk;

   interlaken_latency_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TO),
      .SAMPLES_W   (SAMPLES_W),
      .BIN_SHIFT   (BIN_SHIFT)
   ) dut (
      .init_clk    (init_clk),
      .sys_reset_n (sys_reset_n),
      .clear       (clear),
      .start_lvl   (start_lvl),
      .stop_lvl    (stop_lvl),
      .busy        (busy),
      .meas_valid  (meas_valid),
      .last_lat    (last_lat),
      .min_lat     (min_lat),
      .max_lat     (max_lat),
      .sample_cnt  (sample_cnt),
`ifdef INTERLAKEN_LAT_HIST_EN
      .hist_sel    (hist_sel),
      .hist_cnt    (hist_cnt),
`endif
      .timed_out   (timed_out)
   );

   typedef struct {
      bit               clr;
      int               lat;
      int               pulses;
      logic [CNT_W-1:0] e_last;
      logic [CNT_W-1:0] e_min;
      logic [CNT_W-1:0] e_max;
      int               e_cnt;
      bit               e_to;
   } vec_t;

   vec_t vecs [9];

   // Reference statistics for the random phase
   int m_last, m_min, m_max, m_cnt;
   bit m_to;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic watch(input int n, output int pulses, output logic [CNT_W-1:0] seen);
      pulses = 0;
      seen = last_lat;
      for (int i = 0; i < n; i++) begin
         @(negedge init_clk);
         if (meas_valid === 1'b1) begin
            pulses++;
            seen = last_lat;
         end
      end
   endtask

   task automatic do_clear();
      @(negedge init_clk);
      clear = 1'b1;
      @(negedge init_clk);
      clear = 1'b0;
   endtask

   // Raise start, raise stop lat cycles later, then check pulse and statistics
   task automatic run_meas(input string tag, input int lat, input int e_pulses,
                           input logic [CNT_W-1:0] e_last, input logic [CNT_W-1:0] e_min,
                           input logic [CNT_W-1:0] e_max, input int e_cnt, input bit e_to);
      int p;
      logic [CNT_W-1:0] seen;
      @(negedge init_clk);
      start_lvl = 1'b1;
      repeat (lat) @(negedge init_clk);
      if (lat >= 5 && lat <= TO) check({tag, " busy"}, 64'(busy), 64'd1);
      stop_lvl = 1'b1;
      watch(12, p, seen);
      check({tag, " pulses"}, 64'(p), 64'(e_pulses));
      check({tag, " last"}, 64'(seen), 64'(e_last));
      check({tag, " min"}, 64'(min_lat), 64'(e_min));
      check({tag, " max"}, 64'(max_lat), 64'(e_max));
      check({tag, " cnt"}, 64'(sample_cnt), 64'(e_cnt));
      check({tag, " to"}, 64'(timed_out), 64'(e_to));
      check({tag, " idle"}, 64'(busy), 64'd0);
      start_lvl = 1'b0;
      stop_lvl = 1'b0;
      repeat (6) @(negedge init_clk);
   endtask

   initial begin
      int p;
      int lat;
      logic [CNT_W-1:0] seen;

      vecs[0] = '{1'b1, 100, 1, 100, 100, 100, 1, 1'b0};
      vecs[1] = '{1'b1,  50, 1,  50,  50,  50, 1, 1'b0};
      vecs[2] = '{1'b0, 200, 1, 200,  50, 200, 2, 1'b0};
      vecs[3] = '{1'b0, 120, 1, 120,  50, 200, 3, 1'b0};
      vecs[4] = '{1'b0, 650, 0, 120,  50, 200, 3, 1'b1};
      vecs[5] = '{1'b0,  30, 1,  30,  30, 200, 4, 1'b1};
      vecs[6] = '{1'b0,   1, 1,   1,   1, 200, 5, 1'b1};
      vecs[7] = '{1'b0, TO,  1,  TO,   1,  TO, 6, 1'b1};
      vecs[8] = '{1'b1, TO+1, 0,  0, ONES,  0, 0, 1'b1};

      repeat (3) @(negedge init_clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst valid", 64'(meas_valid), 64'd0);
      check("rst last", 64'(last_lat), 64'd0);
      check("rst min", 64'(min_lat), 64'(ONES));
      check("rst max", 64'(max_lat), 64'd0);
      check("rst cnt", 64'(sample_cnt), 64'd0);
      check("rst to", 64'(timed_out), 64'd0);
      sys_reset_n = 1'b1;
      repeat (4) @(negedge init_clk);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].clr) do_clear();
         run_meas($sformatf("vec%0d", i), vecs[i].lat, vecs[i].pulses, vecs[i].e_last,
                  vecs[i].e_min, vecs[i].e_max, vecs[i].e_cnt, vecs[i].e_to);
      end

      // clear in the middle of a measurement
      do_clear();
      run_meas("pre", 40, 1, 40, 40, 40, 1, 1'b0);
      start_lvl = 1'b1;
      repeat (20) @(negedge init_clk);
      check("clr busy before", 64'(busy), 64'd1);
      clear = 1'b1;
      @(negedge init_clk);
      clear = 1'b0;
      check("clr busy", 64'(busy), 64'd0);
      check("clr min", 64'(min_lat), 64'(ONES));
      check("clr max", 64'(max_lat), 64'd0);
      check("clr cnt", 64'(sample_cnt), 64'd0);
      start_lvl = 1'b0;
      repeat (6) @(negedge init_clk);

      // start and stop on the same edge; stop re-raised 7 cycles later
      @(negedge init_clk);
      start_lvl = 1'b1;
      stop_lvl = 1'b1;
      watch(3, p, seen);
      stop_lvl = 1'b0;
      repeat (4) @(negedge init_clk);
      check("simul busy", 64'(busy), 64'd1);
      stop_lvl = 1'b1;
      watch(12, p, seen);
      check("simul pulses", 64'(p), 64'd1);
      check("simul last", 64'(seen), 64'd7);
      check("simul cnt", 64'(sample_cnt), 64'd1);
      start_lvl = 1'b0;
      stop_lvl = 1'b0;
      repeat (6) @(negedge init_clk);

      // stop pulse alone in IDLE
      stop_lvl = 1'b1;
      repeat (3) @(negedge init_clk);
      stop_lvl = 1'b0;
      watch(12, p, seen);
      check("stoponly pulses", 64'(p), 64'd0);
      check("stoponly cnt", 64'(sample_cnt), 64'd1);
      check("stoponly busy", 64'(busy), 64'd0);

      // asynchronous reset in the middle of a measurement
      start_lvl = 1'b1;
      repeat (20) @(negedge init_clk);
      sys_reset_n = 1'b0;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst last", 64'(last_lat), 64'd0);
      check("arst min", 64'(min_lat), 64'(ONES));
      check("arst cnt", 64'(sample_cnt), 64'd0);
      start_lvl = 1'b0;
      @(negedge init_clk);
      sys_reset_n = 1'b1;
      repeat (6) @(negedge init_clk);

`ifdef INTERLAKEN_LAT_HIST_EN
      begin
         int exp_bins [8];
         int lats [3];
         lats = '{5, 20, 500};
         exp_bins = '{default: 0};
         do_clear();
         m_min = int'(ONES);
         m_max = 0;
         for (int i = 0; i < 3; i++) begin
            m_min = (lats[i] < m_min) ? lats[i] : m_min;
            m_max = (lats[i] > m_max) ? lats[i] : m_max;
            exp_bins[((lats[i] >> BIN_SHIFT) > 7) ? 7 : (lats[i] >> BIN_SHIFT)]++;
            run_meas($sformatf("hist%0d", i), lats[i], 1, lats[i], m_min, m_max, i + 1, 1'b0);
         end
         for (int b = 0; b < 8; b++) begin
            @(negedge init_clk);
            hist_sel = 3'(b);
            @(negedge init_clk);
            check($sformatf("hist bin%0d", b), 64'(hist_cnt), 64'(exp_bins[b]));
         end
      end
`endif

      // random latencies against the reference model
      do_clear();
      m_last = 0; m_min = int'(ONES); m_max = 0; m_cnt = 0; m_to = 1'b0;
      for (int i = 0; i < 25; i++) begin
         lat = $urandom_range(1, TO + 40);
         if (lat <= TO) begin
            m_last = lat;
            m_min = (lat < m_min) ? lat : m_min;
            m_max = (lat > m_max) ? lat : m_max;
            m_cnt++;
         end else begin
            m_to = 1'b1;
         end
         run_meas($sformatf("rnd%0d lat%0d", i, lat), lat, (lat <= TO) ? 1 : 0,
                  m_last, m_min, m_max, m_cnt, m_to);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
